// File: rtl/cpu_pkg.sv
// Shared encodings for the single-cycle RV32I-subset core: opcodes, funct fields,
// ALU operation and write-back selector enums.
package cpu_pkg;

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_JAL   = 7'h6f;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_W    = 3'd2;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_e;

    typedef enum logic [1:0] {WB_ALU, WB_IMM, WB_PC4, WB_MEM} wb_sel_e;

    // alt selects SUB/SRA; callers only set it where funct7 legally means that
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// 32 x 32 register file: two combinational read ports, one write port on clk,
// async active-low clear. x0 is never written so it always reads zero.
module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] regs [0:31];

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end
endmodule

// File: rtl/cpu_top.sv
// Single-cycle RV32I-subset core with internal imem; optional word data memory
// (LW/SW) enabled by defining CPU_DMEM_EN.
module cpu_top
    import cpu_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input logic clk,
    input logic rst
);
    localparam int          IAW     = $clog2(IMEM_DEPTH);
    localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);

    logic [31:0] imem [0:IMEM_DEPTH-1];
    logic [31:0] pc_q, pc_d, pc_plus4, instr;
    logic [31:0] rs1_val, rs2_val, op_b, alu_res, wb_data;
    logic [31:0] imm_i, imm_b, imm_j, imm_u;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic        rd_we, use_imm;
    alu_op_e     alu_op;
    wb_sel_e     wb_sel;

    assign instr    = imem[pc_q[IAW+1:2]];
    assign pc_plus4 = pc_q + 32'd4;
    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign funct7   = instr[31:25];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u    = {instr[31:12], 12'b0};

`ifdef CPU_DMEM_EN
    localparam int DAW = $clog2(DMEM_DEPTH);
    logic [31:0] dmem [0:DMEM_DEPTH-1];
    logic [31:0] imm_s, mem_addr, dmem_rdata;
    logic        dmem_we;

    assign imm_s      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign mem_addr   = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign dmem_rdata = dmem[mem_addr[DAW+1:2]];

    // No reset on the array; gating on rst keeps a reset edge from committing a store
    always_ff @(posedge clk) begin
        if (rst && dmem_we) dmem[mem_addr[DAW+1:2]] <= rs2_val;
    end
`endif

    regfile rf (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .ra2 (rs2),
        .rd1 (rs1_val),
        .rd2 (rs2_val),
        .we  (rd_we),
        .wa  (rd),
        .wd  (wb_data)
    );

    // Decode: anything not recognised falls through with the defaults (a NOP)
    always_comb begin
        alu_op  = ALU_ADD;
        use_imm = 1'b0;
        rd_we   = 1'b0;
        wb_sel  = WB_ALU;
        pc_d    = pc_plus4;
`ifdef CPU_DMEM_EN
        dmem_we = 1'b0;
`endif
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE ||
                    (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR))) begin
                    alu_op = alu_from_f3(funct3, funct7 == F7_ALT);
                    rd_we  = 1'b1;
                end
            end
            OP_I: begin
                use_imm = 1'b1;
                alu_op  = alu_from_f3(funct3, funct3 == F3_SR && funct7 == F7_ALT);
                if (funct3 == F3_SLL)     rd_we = (funct7 == F7_BASE);
                else if (funct3 == F3_SR) rd_we = (funct7 == F7_BASE || funct7 == F7_ALT);
                else                      rd_we = 1'b1;
            end
            OP_LUI: begin
                wb_sel = WB_IMM;
                rd_we  = 1'b1;
            end
            OP_JAL: begin
                wb_sel = WB_PC4;
                rd_we  = 1'b1;
                pc_d   = pc_q + imm_j;
            end
            OP_BR: begin
                if ((funct3 == F3_BEQ && rs1_val == rs2_val) ||
                    (funct3 == F3_BNE && rs1_val != rs2_val))
                    pc_d = pc_q + imm_b;
            end
`ifdef CPU_DMEM_EN
            OP_LOAD: begin
                if (funct3 == F3_W) begin
                    wb_sel = WB_MEM;
                    rd_we  = 1'b1;
                end
            end
            OP_STORE: dmem_we = (funct3 == F3_W);
`endif
            default: ;
        endcase
    end

    assign op_b = use_imm ? imm_i : rs2_val;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = rs1_val + op_b;
            ALU_SUB:  alu_res = rs1_val - op_b;
            ALU_AND:  alu_res = rs1_val & op_b;
            ALU_OR:   alu_res = rs1_val | op_b;
            ALU_XOR:  alu_res = rs1_val ^ op_b;
            ALU_SLL:  alu_res = rs1_val << op_b[4:0];
            ALU_SRL:  alu_res = rs1_val >> op_b[4:0];
            ALU_SRA:  alu_res = $unsigned($signed(rs1_val) >>> op_b[4:0]);
            ALU_SLT:  alu_res = {31'b0, $signed(rs1_val) < $signed(op_b)};
            ALU_SLTU: alu_res = {31'b0, rs1_val < op_b};
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        wb_data = alu_res;
        case (wb_sel)
            WB_IMM:  wb_data = imm_u;
            WB_PC4:  wb_data = pc_plus4;
`ifdef CPU_DMEM_EN
            WB_MEM:  wb_data = dmem_rdata;
`endif
            default: wb_data = alu_res;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= '0;
        else      pc_q <= pc_d & PC_MASK;
    end
endmodule

// File: tb/tb_cpu_top.sv
// Table-driven program bench for cpu_top: each vector loads a short program,
// pushes its expected register values to a scoreboard, runs, then pops and compares.
module tb_cpu_top;
    logic clk;
    logic rst;

    cpu_top #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (.clk(clk), .rst(rst));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][31:0] prog;
        logic [3:0][4:0]  ereg;
        logic [3:0][31:0] eval;
        logic [2:0]       nexp;
    } vec_t;

    typedef struct {
        int          vi;
        logic [4:0]  r;
        logic [31:0] v;
    } exp_t;

    vec_t vecs [9];
    exp_t sbq [$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [31:0] enc_i(logic [6:0] op, logic [4:0] rd, logic [2:0] f3,
                                          logic [4:0] rs1, logic [31:0] imm);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(logic [31:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction
    function automatic logic [31:0] addi(logic [4:0] rd, logic [4:0] rs1, logic [31:0] imm);
        return enc_i(7'h13, rd, 3'd0, rs1, imm);
    endfunction

    localparam logic [31:0] NOP = 32'h0000_0013;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_imem(logic [31:0] w);
        for (int i = 0; i < 256; i++) dut.imem[i] = w;
    endtask

    task automatic apply_vec(int vi);
        @(negedge clk);
        rst = 1'b0;
        #1;
        fill_imem(NOP);
        for (int k = 0; k < 8; k++) dut.imem[k] = vecs[vi].prog[k];
        for (int k = 0; k < int'(vecs[vi].nexp); k++)
            sbq.push_back('{vi: vi, r: vecs[vi].ereg[k], v: vecs[vi].eval[k]});
        @(negedge clk);
        rst = 1'b1;
        run(50);
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check($sformatf("vec%0d x%0d", e.vi, e.r), dut.rf.regs[e.r], e.v);
        end
    endtask

    task automatic set_exp(int vi, int k, logic [4:0] r, logic [31:0] v);
        vecs[vi].ereg[k] = r;
        vecs[vi].eval[k] = v;
        vecs[vi].nexp    = 3'(k + 1);
    endtask

    initial begin
        logic [31:0] dmem_x2;
        int          nz;
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            vecs[i].prog = {8{NOP}};
            vecs[i].ereg = '0;
            vecs[i].eval = '0;
            vecs[i].nexp = '0;
        end

        // basic add
        vecs[0].prog[0] = addi(1, 0, 5);
        vecs[0].prog[1] = addi(2, 0, 7);
        vecs[0].prog[2] = enc_r(7'h00, 2, 1, 3'd0, 3, 7'h33);
        set_exp(0, 0, 1, 5); set_exp(0, 1, 2, 7); set_exp(0, 2, 3, 12);
        // sub wrap and signed compare
        vecs[1].prog[0] = addi(1, 0, 3);
        vecs[1].prog[1] = addi(2, 0, 5);
        vecs[1].prog[2] = enc_r(7'h20, 2, 1, 3'd0, 3, 7'h33);
        vecs[1].prog[3] = enc_r(7'h00, 0, 3, 3'd2, 4, 7'h33);
        set_exp(1, 0, 3, 32'hFFFF_FFFE); set_exp(1, 1, 4, 1);
        // x0 write discarded
        vecs[2].prog[0] = addi(0, 0, 9);
        vecs[2].prog[1] = addi(1, 0, 1);
        set_exp(2, 0, 0, 0); set_exp(2, 1, 1, 1);
        // taken BEQ skips one instruction
        vecs[3].prog[0] = addi(1, 0, 1);
        vecs[3].prog[1] = enc_b(8, 1, 1, 3'd0);
        vecs[3].prog[2] = addi(2, 0, 99);
        vecs[3].prog[3] = addi(3, 0, 4);
        set_exp(3, 0, 2, 0); set_exp(3, 1, 3, 4);
        // store then load
        vecs[4].prog[0] = addi(1, 0, 42);
        vecs[4].prog[1] = enc_s(8, 1, 0);
        vecs[4].prog[2] = enc_i(7'h03, 2, 3'd2, 0, 8);
`ifdef CPU_DMEM_EN
        dmem_x2 = 42;
`else
        dmem_x2 = 0;
`endif
        set_exp(4, 0, 2, dmem_x2); set_exp(4, 1, 1, 42);
        // shifts and unsigned compare
        vecs[5].prog[0] = addi(1, 0, -16);
        vecs[5].prog[1] = enc_i(7'h13, 2, 3'd5, 1, {20'h0, 7'h20, 5'd2});
        vecs[5].prog[2] = enc_i(7'h13, 3, 3'd5, 1, 28);
        vecs[5].prog[3] = enc_r(7'h00, 1, 0, 3'd3, 4, 7'h33);
        set_exp(5, 0, 2, 32'hFFFF_FFFC); set_exp(5, 1, 3, 32'h0000_000F);
        set_exp(5, 2, 4, 1);             set_exp(5, 3, 1, 32'hFFFF_FFF0);
        // LUI, logic immediates, shift amount uses only low 5 bits
        vecs[6].prog[0] = {20'h12345, 5'd1, 7'h37};
        vecs[6].prog[1] = enc_i(7'h13, 2, 3'd4, 1, -1);
        vecs[6].prog[2] = enc_i(7'h13, 3, 3'd6, 0, 32'h7FF);
        vecs[6].prog[3] = enc_r(7'h00, 3, 3, 3'd1, 4, 7'h33);
        set_exp(6, 0, 1, 32'h1234_5000); set_exp(6, 1, 2, 32'hEDCB_AFFF);
        set_exp(6, 2, 3, 32'h0000_07FF); set_exp(6, 3, 4, 32'h8000_0000);
        // JAL link and skip, taken BNE
        vecs[7].prog[0] = enc_j(8, 1);
        vecs[7].prog[1] = addi(2, 0, 1);
        vecs[7].prog[2] = addi(3, 0, 2);
        vecs[7].prog[3] = enc_b(8, 0, 3, 3'd1);
        vecs[7].prog[4] = addi(4, 0, 9);
        vecs[7].prog[5] = addi(5, 0, 6);
        set_exp(7, 0, 1, 4); set_exp(7, 1, 2, 0); set_exp(7, 2, 4, 0); set_exp(7, 3, 5, 6);
        // unsupported encodings act as NOPs
        vecs[8].prog[0] = addi(5, 0, 2);
        vecs[8].prog[1] = enc_r(7'h01, 5, 5, 3'd0, 1, 7'h33);
        vecs[8].prog[2] = enc_r(7'h00, 0, 0, 3'd0, 2, 7'h7f);
        vecs[8].prog[3] = enc_i(7'h13, 3, 3'd1, 5, {20'h0, 7'h20, 5'd1});
        set_exp(8, 0, 1, 0); set_exp(8, 1, 2, 0); set_exp(8, 2, 3, 0); set_exp(8, 3, 5, 2);

        for (int vi = 0; vi < 9; vi++) begin
            apply_vec(vi);
`ifdef CPU_DMEM_EN
            if (vi == 4) check("dmem[2]", dut.dmem[2], 32'd42);
`endif
        end

        // mid-program async reset, restart from imem[0], and PC wrap
        @(negedge clk);
        rst = 1'b0;
        #1;
        fill_imem(addi(1, 1, 1));
        @(negedge clk);
        rst = 1'b1;
        run(10);
        check("count x1", dut.rf.regs[1], 10);
        check("count pc", dut.pc_q, 40);
        #2 rst = 1'b0;
        #1;
        check("async rst pc", dut.pc_q, 0);
        nz = 0;
        for (int r = 1; r < 32; r++) if (dut.rf.regs[r] !== 32'd0) nz++;
        check("async rst nonzero regs", 32'(nz), 0);
        @(negedge clk);
        rst = 1'b1;
        run(3);
        check("restart x1", dut.rf.regs[1], 3);
        check("restart pc", dut.pc_q, 12);
        run(253);
        check("wrap pc", dut.pc_q, 0);
        check("wrap x1", dut.rf.regs[1], 256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_top.md
CPU_TOP -- requirements
Module: cpu_top

Interface
REQ-001 Parameter: IMEM_DEPTH, 256, number of 32-bit instruction words in the internal instruction memory.
REQ-002 Parameter: DMEM_DEPTH, 256, number of 32-bit data words in the internal data memory.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-005 No other ports exist; the bench observes state hierarchically.
REQ-006 Instruction memory SHALL be an unpacked array named imem, [0:IMEM_DEPTH-1] of 32 bits, directly inside cpu_top and loadable by $readmemh.
REQ-007 Register file SHALL be an instance named rf whose array is named regs, [0:31] of 32 bits.

Function
REQ-008 Single-cycle RV32I subset: one instruction fetched, decoded, executed and retired per clk rising edge.
REQ-009 Fetch SHALL read imem combinationally at index pc[log2(IMEM_DEPTH)+1:2]; the PC wraps modulo IMEM_DEPTH*4.
REQ-010 Supported R-type: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
REQ-011 Supported I-type ALU: ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI; 12-bit immediate sign-extended.
REQ-012 Supported LUI (imm<<12), JAL (rd=pc+4, pc+=sign-extended J-imm), BEQ and BNE (pc+=sign-extended B-imm when taken).
REQ-013 Arithmetic SHALL be 32-bit modulo 2^32; shift amount = operand[4:0]; SLT signed, SLTU unsigned.
REQ-014 Next PC SHALL be pc+4 unless a branch is taken or JAL executes.
REQ-015 Any unsupported opcode or funct combination SHALL execute as a NOP (pc+4, no register or memory write).
REQ-016 regs[0] SHALL always read 0; writes to x0 are discarded.
REQ-017 Register reads SHALL be combinational, with writes on the clock edge; a same-cycle read of the register being written returns the old value.
REQ-018 Each instruction writes at most one register, at the rising edge that ends its cycle.

Reset
REQ-019 While rst=0: pc=0 and regs[1..31]=0, taking effect immediately and independently of clk.
REQ-020 Reset asserted mid-program SHALL abandon the current instruction with no partial write.
REQ-021 After rst rises, the first instruction executed SHALL be imem[0].
REQ-022 imem and dmem contents SHALL NOT be cleared by reset.

Configuration
REQ-023 Macro CPU_DMEM_EN: when defined, LW and SW are supported on a word array dmem[0:DMEM_DEPTH-1]. Address = rs1+sign-extended imm, word index addr[log2(DMEM_DEPTH)+1:2]. SW writes on the clock edge; LW reads combinationally.
REQ-024 Without CPU_DMEM_EN, dmem SHALL NOT exist and LW/SW SHALL execute as NOPs.

Structure
REQ-025 A package cpu_pkg SHALL hold the opcode constants, funct3/funct7 constants and the ALU-operation enum typedef.
REQ-026 Module regfile (instance rf) SHALL be the one sub-module: two combinational read ports, one synchronous write port, async active-low reset.
REQ-027 Decode, ALU, immediate generation, PC logic, imem and dmem SHALL reside in cpu_top.

Verification
REQ-028 imem = ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2; rst released, 50 cycles -> x1=5, x2=7, x3=12.
REQ-029 ADDI x1,x0,3; ADDI x2,x0,5; SUB x3,x1,x2; SLT x4,x3,x0 -> x3=0xFFFFFFFE, x4=1.
REQ-030 ADDI x0,x0,9; ADDI x1,x0,1 -> x0=0, x1=1.
REQ-031 ADDI x1,x0,1; BEQ x1,x1,+8; ADDI x2,x0,99; ADDI x3,x0,4 -> x2=0, x3=4.
REQ-032 With CPU_DMEM_EN: ADDI x1,x0,42; SW x1,8(x0); LW x2,8(x0) -> x2=42, dmem[2]=42. Without CPU_DMEM_EN the same program gives x2=0.
REQ-033 Assert rst=0 mid-program between clock edges -> pc and x1..x31 become 0 before the next edge, and execution restarts at imem[0] after release.
